// File: rtl/reg_fwd_scoreboard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types for the EX-stage forwarding / RAW-hazard unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int FWD_DATA_W = 32;
  localparam int FWD_ADDR_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  typedef struct packed {
    logic                  we;
    logic                  valid;
    logic [FWD_ADDR_W-1:0] waddr;
    logic [FWD_DATA_W-1:0] wdata;
  } fwd_src_t;

endpackage

`default_nettype wire

// File: rtl/reg_fwd_scoreboard_if.sv
// ============================================================================
// Module   : reg_fwd_scoreboard_if
// Brief    : Read-port, forwarding-source and multi-cycle issue bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reg_fwd_scoreboard_if #(
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_FWD      = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LAT_W        = 6,
  parameter int CNT_W        = 32
);

  logic [NUM_RD_PORTS-1:0]             rd_req_i;
  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0] rd_data_i;
  logic [NUM_FWD-1:0]                  fwd_we_i;
  logic [NUM_FWD-1:0]                  fwd_valid_i;
  logic [NUM_FWD-1:0][ADDR_W-1:0]      fwd_waddr_i;
  logic [NUM_FWD-1:0][DATA_W-1:0]      fwd_wdata_i;
  logic                                mc_issue_i;
  logic [ADDR_W-1:0]                   mc_waddr_i;
  logic [LAT_W-1:0]                    mc_lat_i;
  logic                                flush_i;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0] rd_data_o;
  logic                                stall_o;
  logic                                mc_busy_o;
  logic [CNT_W-1:0]                    stall_cnt_o;

  modport master (
    output rd_req_i, rd_addr_i, rd_data_i,
    output fwd_we_i, fwd_valid_i, fwd_waddr_i, fwd_wdata_i,
    output mc_issue_i, mc_waddr_i, mc_lat_i, flush_i,
    input  rd_data_o, stall_o, mc_busy_o, stall_cnt_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i, rd_data_i,
    input  fwd_we_i, fwd_valid_i, fwd_waddr_i, fwd_wdata_i,
    input  mc_issue_i, mc_waddr_i, mc_lat_i, flush_i,
    output rd_data_o, stall_o, mc_busy_o, stall_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/reg_fwd_scoreboard_fwd_port_sel.sv
// ============================================================================
// Module   : fwd_port_sel
// Brief    : One read port: priority forwarding select plus RAW hazard flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_port_sel
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 2
) (
  input  logic                  rd_req_i,
  input  logic [FWD_ADDR_W-1:0] rd_addr_i,
  input  logic [FWD_DATA_W-1:0] rd_data_i,
  input  fwd_src_t              src_i [NUM_FWD],
  input  logic                  sb_live_i,
  input  logic [FWD_ADDR_W-1:0] sb_addr_i,
  output logic [FWD_DATA_W-1:0] data_o,
  output logic                  hazard_o
);

  logic found;

  always_comb begin
    data_o   = rd_data_i;
    hazard_o = 1'b0;
    found    = 1'b0;
    if (rd_addr_i == '0) begin
      data_o = '0;
    end else begin
      // Index 0 is the youngest producer, so the first hit wins.
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && src_i[i].we && (src_i[i].waddr == rd_addr_i)) begin
          found    = 1'b1;
          data_o   = src_i[i].wdata;
          hazard_o = rd_req_i && !src_i[i].valid;
        end
      end
      if (rd_req_i && sb_live_i && (sb_addr_i == rd_addr_i)) begin
        hazard_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_fwd_scoreboard.sv
// ============================================================================
// Module   : reg_fwd_scoreboard
// Brief    : EX-stage operand forwarding, RAW stall and multi-cycle scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_fwd_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_FWD      = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LAT_W        = 6,
  parameter int CNT_W        = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  reg_fwd_scoreboard_if.slave  bus
);

  mc_state_e                           state_q, state_d;
  logic [LAT_W-1:0]                    cnt_q, cnt_d;
  logic [ADDR_W-1:0]                   busy_addr_q, busy_addr_d;
  logic [CNT_W-1:0]                    stall_cnt_q, stall_cnt_d;

  fwd_src_t                            src [NUM_FWD];
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0] port_data;
  logic [NUM_RD_PORTS-1:0]             port_haz;
  logic                                sb_live;
  logic                                struct_haz;
  logic                                stall;
  logic                                issue_ok;
  logic [LAT_W-1:0]                    lat_eff;

  always_comb begin
    for (int i = 0; i < NUM_FWD; i++) begin
      src[i] = '{we:    bus.fwd_we_i[i],
                 valid: bus.fwd_valid_i[i],
                 waddr: bus.fwd_waddr_i[i],
                 wdata: bus.fwd_wdata_i[i]};
    end
  end

  // A zero destination still occupies the unit but never blocks a reader.
  assign sb_live = (state_q == BUSY) && (busy_addr_q != '0);

  generate
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      fwd_port_sel #(
        .NUM_FWD (NUM_FWD)
      ) u_sel (
        .rd_req_i  (bus.rd_req_i[p]),
        .rd_addr_i (bus.rd_addr_i[p]),
        .rd_data_i (bus.rd_data_i[p]),
        .src_i     (src),
        .sb_live_i (sb_live),
        .sb_addr_i (busy_addr_q),
        .data_o    (port_data[p]),
        .hazard_o  (port_haz[p])
      );
    end
  endgenerate

  assign struct_haz = bus.mc_issue_i && (state_q == BUSY) && (cnt_q != LAT_W'(1));
  assign stall      = !rst_i && ((|port_haz) || struct_haz);
  assign issue_ok   = bus.mc_issue_i && !stall;
  assign lat_eff    = (bus.mc_lat_i == '0) ? LAT_W'(1) : bus.mc_lat_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_addr_d = busy_addr_q;
    stall_cnt_d = stall_cnt_q;

    if (issue_ok) begin
      state_d     = BUSY;
      cnt_d       = lat_eff;
      busy_addr_d = bus.mc_waddr_i;
    end else if (state_q == BUSY) begin
      if (cnt_q == LAT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end

    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_addr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_addr_q <= busy_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.rd_data_o   = rst_i ? '0 : port_data;
  assign bus.stall_o     = stall;
  assign bus.mc_busy_o   = (state_q == BUSY);
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire
